div: RTL

//   Multi-cycle unsigned integer divider; the inverse companion of the ALU multiply unit.

---
 rtl/div.sv | 119 +++++++++++
 1 files changed

// File: rtl/div.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor completes in a single cycle with an all-ones quotient and dz set.
module div #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] rs1_reg,
  input  logic [N-1:0] rs2_reg,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] div_rd,
  output logic [N-1:0] d_rem,
  output logic         dz
);

  localparam int unsigned CntW = $clog2(N + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    div_rd_q, div_rd_d;
  logic [N-1:0]    d_rem_q, d_rem_d;
  logic            dz_q, dz_d;

  // The shifted partial remainder is N+1 bits wide so the compare never overflows;
  // once restored it is always below the divisor and therefore fits back into N bits.
  logic [N:0]   shifted;
  logic         ge;
  logic [N-1:0] sub;

  always_comb begin
    shifted = {acc_q, q_q[N-1]};
    ge      = shifted >= {1'b0, dvs_q};
    sub     = shifted[N-1:0] - dvs_q;
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    div_rd_d = div_rd_q;
    d_rem_d  = d_rem_q;
    dz_d     = dz_q;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          dvs_d = rs2_reg;
          if (rs2_reg == '0) begin
            state_d  = StDone;
            div_rd_d = '1;
            d_rem_d  = rs1_reg;
            dz_d     = 1'b1;
          end else begin
            state_d = StBusy;
            acc_d   = '0;
            q_d     = rs1_reg;
            cnt_d   = CntW'(N);
          end
        end else begin
          state_d = StIdle;
        end
      end

      StBusy: begin
        acc_d = ge ? sub : shifted[N-1:0];
        q_d   = {q_q[N-2:0], ge};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d  = StDone;
          div_rd_d = q_d;
          d_rem_d  = acc_d;
          dz_d     = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      q_q      <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      div_rd_q <= '0;
      d_rem_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      div_rd_q <= div_rd_d;
      d_rem_q  <= d_rem_d;
      dz_q     <= dz_d;
    end
  end

  assign busy   = (state_q == StBusy);
  assign done   = (state_q == StDone);
  assign div_rd = div_rd_q;
  assign d_rem  = d_rem_q;
  assign dz     = dz_q;

endmodule
